// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data-memory load/store unit.
// Holds the access-size encodings, the LSU FSM state enum, the default
// memory latency and the captured-request payload struct.
package data_mem_pkg;

   localparam int unsigned MEM_LAT_DEF = 4;
   localparam int unsigned XLEN        = 32;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2,
      SZ_RSVD = 2'd3
   } size_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LD_WAIT = 2'd1,
      RMW_RD  = 2'd2,
      RMW_WR  = 2'd3
   } state_e;

   // Request fields frozen at acceptance
   typedef struct packed {
      size_e            size;
      logic             is_unsigned;
      logic [1:0]       offset;
      logic [XLEN-1:0]  wdata;
   } lsu_req_t;

   // Reserved size code behaves as a word access
   function automatic size_e norm_size(input logic [1:0] s);
      return (s == 2'd3) ? SZ_WORD : size_e'(s);
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic for the LSU.
//   size, is_unsigned, offset : captured request attributes (offset already aligned)
//   rd_word                   : word returned by the data memory
//   wdata                     : right-justified store data
//   ld_data_c                 : selected lane, sign/zero extended
//   st_word_c                 : rd_word with the store lanes replaced by wdata
module lsu_lane_align
   import data_mem_pkg::*;
(
   input  size_e       size,
   input  logic        is_unsigned,
   input  logic [1:0]  offset,
   input  logic [31:0] rd_word,
   input  logic [31:0] wdata,
   output logic [31:0] ld_data_c,
   output logic [31:0] st_word_c
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Load lane extract and extension
   always_comb begin
      byte_sel = rd_word[7:0];
      case (offset)
         2'd0:    byte_sel = rd_word[7:0];
         2'd1:    byte_sel = rd_word[15:8];
         2'd2:    byte_sel = rd_word[23:16];
         default: byte_sel = rd_word[31:24];
      endcase
      half_sel = offset[1] ? rd_word[31:16] : rd_word[15:0];

      case (size)
         SZ_BYTE: ld_data_c = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
         SZ_HALF: ld_data_c = {{16{~is_unsigned & half_sel[15]}}, half_sel};
         default: ld_data_c = rd_word;
      endcase
   end

   // Store merge: only the addressed lanes take new data
   always_comb begin
      st_word_c = rd_word;
      case (size)
         SZ_BYTE: begin
            case (offset)
               2'd0:    st_word_c[7:0]   = wdata[7:0];
               2'd1:    st_word_c[15:8]  = wdata[7:0];
               2'd2:    st_word_c[23:16] = wdata[7:0];
               default: st_word_c[31:24] = wdata[7:0];
            endcase
         end
         SZ_HALF: begin
            if (offset[1]) st_word_c[31:16] = wdata[15:0];
            else           st_word_c[15:0]  = wdata[15:0];
         end
         default: st_word_c = wdata;
      endcase
   end

endmodule

// File: rtl/data_mem_lsu.sv
// Load/store unit between a CPU request port and a pipelined data memory.
// One request outstanding; word stores complete in one cycle, loads wait
// MEM_LAT cycles for read data, byte/half stores do read-modify-write.
//   clk, rst_n                      : clock, async active-low reset
//   req_valid/req_ready             : request handshake (ready only when idle)
//   req_we, req_addr, req_size,
//   req_unsigned, req_wdata         : request payload
//   rsp_valid, rsp_rdata, rsp_err   : one-cycle completion
//   mem_addr, mem_we, mem_din       : memory command (registered)
//   mem_dout                        : memory read data, MEM_LAT cycles after mem_addr
// Build option: define DATA_MEM_LSU_MISALIGN_TRAP_EN to flag misaligned
// half/word accesses with rsp_err instead of forcing them aligned.
// MEM_LAT must be at least 1.
module data_mem_lsu
   import data_mem_pkg::*;
#(
   parameter int unsigned MEM_LAT = MEM_LAT_DEF,
   parameter int unsigned AW      = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [31:0]   req_addr,
   input  logic [1:0]    req_size,
   input  logic          req_unsigned,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err,
   output logic [AW-1:0] mem_addr,
   output logic          mem_we,
   output logic [31:0]   mem_din,
   input  logic [31:0]   mem_dout
);

   localparam int unsigned CW = $clog2(MEM_LAT + 1);

   state_e        state;
   logic [CW-1:0] cnt;
   lsu_req_t      req_q;
   logic          ld_rsp_q;
   size_e         req_sz_c;
   logic [1:0]    req_off_c;
   logic          trap_c;
   logic [31:0]   ld_data_c;
   logic [31:0]   st_word_c;
   logic          unused_addr_hi;

   // Word address bits above AW are don't-care
   assign unused_addr_hi = ^req_addr[31:AW+2];

   assign req_ready = (state == IDLE);

   // Effective size and lane offset; half/word drop the sub-lane address bits
   always_comb begin
      req_sz_c = norm_size(req_size);
      case (req_sz_c)
         SZ_BYTE: req_off_c = req_addr[1:0];
         SZ_HALF: req_off_c = {req_addr[1], 1'b0};
         default: req_off_c = 2'b00;
      endcase
   end

`ifdef DATA_MEM_LSU_MISALIGN_TRAP_EN
   logic err_q;

   assign trap_c = ((req_sz_c == SZ_HALF) && req_addr[0]) ||
                   ((req_sz_c == SZ_WORD) && (req_addr[1:0] != 2'b00));

   // Error pulse accompanies the immediate trap response
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= req_valid && req_ready && trap_c;
   end

   assign rsp_err = err_q;
`else
   assign trap_c  = 1'b0;
   assign rsp_err = 1'b0;
`endif

   lsu_lane_align u_lane (
      .size        (req_q.size),
      .is_unsigned (req_q.is_unsigned),
      .offset      (req_q.offset),
      .rd_word     (mem_dout),
      .wdata       (req_q.wdata),
      .ld_data_c   (ld_data_c),
      .st_word_c   (st_word_c)
   );

   // Load data is taken straight from mem_dout in its valid cycle
   assign rsp_rdata = ld_rsp_q ? ld_data_c : 32'h0;

   // Request sequencing; counter marks the cycle read data arrives
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         req_q     <= '0;
         ld_rsp_q  <= 1'b0;
         rsp_valid <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_din   <= '0;
      end else begin
         rsp_valid <= 1'b0;
         mem_we    <= 1'b0;
         ld_rsp_q  <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (trap_c) begin
                     rsp_valid <= 1'b1;
                  end else begin
                     req_q    <= '{size: req_sz_c, is_unsigned: req_unsigned,
                                   offset: req_off_c, wdata: req_wdata};
                     mem_addr <= req_addr[AW+1:2];
                     if (!req_we) begin
                        state <= LD_WAIT;
                        cnt   <= CW'(MEM_LAT);
                     end else if (req_sz_c == SZ_WORD) begin
                        mem_we    <= 1'b1;
                        mem_din   <= req_wdata;
                        rsp_valid <= 1'b1;
                     end else begin
                        state <= RMW_RD;
                        cnt   <= CW'(MEM_LAT);
                     end
                  end
               end
            end
            LD_WAIT: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b1;
                  ld_rsp_q  <= 1'b1;
               end
            end
            RMW_RD: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= RMW_WR;
            end
            RMW_WR: begin
               // mem_dout holds the old word this cycle
               mem_we    <= 1'b1;
               mem_din   <= st_word_c;
               rsp_valid <= 1'b1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Bench for data_mem_lsu: directed vector table, hand-written reset and
// back-to-back sequences, and random traffic against a word-array model.
module tb_data_mem_lsu;

   localparam int unsigned LAT = 4;
   localparam int unsigned AW  = 10;
   localparam int unsigned DEPTH = 1 << AW;
`ifdef DATA_MEM_LSU_MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [31:0]   req_addr;
   logic [1:0]    req_size;
   logic          req_unsigned;
   logic [31:0]   req_wdata;
   logic          rsp_valid;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [31:0]   mem_din;
   logic [31:0]   mem_dout;

   data_mem_lsu #(.MEM_LAT(LAT), .AW(AW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .mem_addr     (mem_addr),
      .mem_we       (mem_we),
      .mem_din      (mem_din),
      .mem_dout     (mem_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pipelined memory: data appears LAT cycles after the address
   logic [31:0] mem  [0:DEPTH-1];
   logic [31:0] pipe [0:LAT-1];
   logic        mem_clear;

   always @(posedge clk) begin
      if (mem_clear) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 32'h0;
         for (int i = 0; i < int'(LAT); i++) pipe[i] <= 32'h0;
      end else begin
         if (mem_we) mem[mem_addr] <= mem_din;
         pipe[0] <= mem[mem_addr];
         for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
      end
   end
   assign mem_dout = pipe[LAT-1];

   int checks = 0;
   int errors = 0;
   logic [31:0] ref_mem [0:DEPTH-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference: spec rules applied to a plain word array
   task automatic model(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        output logic [31:0] rd, output int lat, output logic err, output logic wr);
      int sz, off, idx;
      logic [31:0] w, mask;
      sz  = (size == 2'd3) ? 2 : int'(size);
      off = int'(addr[1:0]);
      rd = 32'h0; err = 1'b0; wr = 1'b0; lat = 1;
      if (TRAP && ((sz == 1 && (off % 2) != 0) || (sz == 2 && off != 0))) begin
         err = 1'b1;
         return;
      end
      if (sz == 1) off = off - (off % 2);
      if (sz == 2) off = 0;
      idx = int'(addr[AW+1:2]);
      w   = ref_mem[idx];
      if (!we) begin
         lat = int'(LAT) + 1;
         if (sz == 0) begin
            rd = (w >> (8 * off)) & 32'hFF;
            if (!uns && rd[7]) rd = rd | 32'hFFFF_FF00;
         end else if (sz == 1) begin
            rd = (w >> (8 * off)) & 32'hFFFF;
            if (!uns && rd[15]) rd = rd | 32'hFFFF_0000;
         end else begin
            rd = w;
         end
      end else begin
         wr = 1'b1;
         if (sz == 2) begin
            lat = 1;
            ref_mem[idx] = wdata;
         end else begin
            mask = (sz == 0) ? 32'hFF : 32'hFFFF;
            lat  = int'(LAT) + 2;
            ref_mem[idx] = (w & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
         end
      end
   endtask

   // One transaction: handshake, then scramble inputs, then wait for rsp_valid
   task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic [31:0] wdata,
                         output logic [31:0] rdata, output int lat, output logic err,
                         output logic we_rsp, output int nwe, output logic [AW-1:0] waddr);
      int guard;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
      req_unsigned = uns; req_wdata = wdata;
      guard = 0;
      while (!req_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom;
      req_size = 2'($urandom); req_unsigned = 1'($urandom); req_wdata = $urandom;
      rdata = 32'h0; lat = 0; err = 1'b0; we_rsp = 1'b0; nwe = 0; waddr = '0;
      for (int c = 1; c <= 50; c++) begin
         @(negedge clk);
         if (mem_we) begin
            nwe++;
            waddr = mem_addr;
         end
         if (rsp_valid) begin
            lat = c; rdata = rsp_rdata; err = rsp_err; we_rsp = mem_we;
            break;
         end
      end
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [1:0]  size;
      logic        uns;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_lat;
      logic        exp_err;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(logic we, logic [31:0] addr, logic [1:0] size, logic uns,
                               logic [31:0] wdata, logic [31:0] exp_rdata, int exp_lat,
                               logic exp_err);
      vec_t v;
      v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
      v.exp_rdata = exp_rdata; v.exp_lat = exp_lat; v.exp_err = exp_err;
      return v;
   endfunction

   // Compare one observed transaction against expected values
   task automatic chk_txn(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] rd, input int lat, input logic err,
                          input logic we_rsp, input int nwe, input logic [AW-1:0] waddr,
                          input logic [31:0] e_rd, input int e_lat, input logic e_err,
                          input logic e_wr);
      chk({tag, "_rdata"}, rd, e_rd);
      chk({tag, "_latency"}, 32'(lat), 32'(e_lat));
      chk({tag, "_err"}, 32'(err), 32'(e_err));
      chk({tag, "_we_at_rsp"}, 32'(we_rsp), 32'(e_wr));
      chk({tag, "_we_count"}, 32'(nwe), e_wr ? 32'd1 : 32'd0);
      if (e_wr) chk({tag, "_we_addr"}, 32'(waddr), 32'(addr[AW+1:2]));
   endtask

   logic [31:0]   rd, m_rd;
   int            lat, m_lat, nwe;
   logic          err, m_err, we_rsp, m_wr;
   logic [AW-1:0] waddr;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int nbad, saw, n_acc, n_rsp, guard;
      logic [31:0] b2b_addr [0:2];
      logic [31:0] b2b_exp  [0:2];
      logic        we_r, uns_r;
      logic [31:0] addr_r, wdata_r;
      logic [1:0]  size_r;

      for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = 32'h0;
      rst_n = 1'b0; mem_clear = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_size = 2'd0;
      req_unsigned = 1'b0; req_wdata = 32'h0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_err", 32'(rsp_err), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_din", mem_din, 32'h0);
      mem_clear = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);

      // Directed vectors
      vt.push_back(mk(1, 32'h10, 2, 0, 32'hDEADBEEF, 32'h0, 1, 0));
      vt.push_back(mk(0, 32'h10, 2, 0, 32'h0, 32'hDEADBEEF, LAT + 1, 0));
      vt.push_back(mk(1, 32'h10, 2, 0, 32'h80FF0102, 32'h0, 1, 0));
      vt.push_back(mk(0, 32'h13, 0, 0, 32'h0, 32'hFFFFFF80, LAT + 1, 0));
      vt.push_back(mk(0, 32'h13, 0, 1, 32'h0, 32'h00000080, LAT + 1, 0));
      vt.push_back(mk(1, 32'h10, 2, 0, 32'h11223344, 32'h0, 1, 0));
      vt.push_back(mk(1, 32'h11, 0, 0, 32'hFFFFFFAA, 32'h0, LAT + 2, 0));
      vt.push_back(mk(0, 32'h10, 2, 0, 32'h0, 32'h1122AA44, LAT + 1, 0));
      vt.push_back(mk(0, 32'h12, 1, 0, 32'h0, 32'h00001122, LAT + 1, 0));
      vt.push_back(mk(0, 32'h10, 1, 0, 32'h0, 32'hFFFFAA44, LAT + 1, 0));
      vt.push_back(mk(0, 32'h10, 1, 1, 32'h0, 32'h0000AA44, LAT + 1, 0));
      vt.push_back(mk(1, 32'h12, 1, 0, 32'h1234BEEF, 32'h0, LAT + 2, 0));
      vt.push_back(mk(0, 32'h10, 2, 0, 32'h0, 32'hBEEFAA44, LAT + 1, 0));
      vt.push_back(mk(0, 32'h11, 0, 0, 32'h0, 32'hFFFFFFAA, LAT + 1, 0));
      vt.push_back(mk(0, 32'hFFFF_F010, 3, 0, 32'h0, 32'hBEEFAA44, LAT + 1, 0));
      vt.push_back(mk(1, 32'h00, 2, 0, 32'h0BADF00D, 32'h0, 1, 0));
      if (TRAP) begin
         vt.push_back(mk(0, 32'h02, 2, 0, 32'h0, 32'h0, 1, 1));
         vt.push_back(mk(0, 32'h03, 1, 0, 32'h0, 32'h0, 1, 1));
         vt.push_back(mk(1, 32'h01, 1, 0, 32'h5555, 32'h0, 1, 1));
         vt.push_back(mk(0, 32'h00, 2, 0, 32'h0, 32'h0BADF00D, LAT + 1, 0));
      end else begin
         vt.push_back(mk(0, 32'h02, 2, 0, 32'h0, 32'h0BADF00D, LAT + 1, 0));
         vt.push_back(mk(0, 32'h03, 1, 0, 32'h0, 32'h00000BAD, LAT + 1, 0));
         vt.push_back(mk(1, 32'h01, 1, 0, 32'h5555, 32'h0, LAT + 2, 0));
         vt.push_back(mk(0, 32'h00, 2, 0, 32'h0, 32'h0BAD5555, LAT + 1, 0));
      end

      foreach (vt[i]) begin
         do_req(vt[i].we, vt[i].addr, vt[i].size, vt[i].uns, vt[i].wdata,
                rd, lat, err, we_rsp, nwe, waddr);
         model(vt[i].we, vt[i].addr, vt[i].size, vt[i].uns, vt[i].wdata,
               m_rd, m_lat, m_err, m_wr);
         chk_txn($sformatf("vec%0d", i), vt[i].we, vt[i].addr, rd, lat, err, we_rsp, nwe,
                 waddr, vt[i].exp_rdata, vt[i].exp_lat, vt[i].exp_err,
                 vt[i].we && !vt[i].exp_err);
      end

      // Reset while a load is waiting for data
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 2'd2;
      @(posedge clk);
      #1 req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("ldwait_req_ready", 32'(req_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_rsp_rdata", rsp_rdata, 32'h0);
      chk("midrst_mem_we", 32'(mem_we), 32'd0);
      chk("midrst_mem_addr", 32'(mem_addr), 32'd0);
      chk("midrst_req_ready", 32'(req_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      saw = 0;
      for (int c = 0; c < int'(LAT) + 4; c++) begin
         @(negedge clk);
         if (rsp_valid || mem_we) saw++;
      end
      chk("postrst_stray_activity", 32'(saw), 32'd0);
      chk("postrst_req_ready", 32'(req_ready), 32'd1);
      do_req(0, 32'h10, 2, 0, 32'h0, rd, lat, err, we_rsp, nwe, waddr);
      model(0, 32'h10, 2, 0, 32'h0, m_rd, m_lat, m_err, m_wr);
      chk_txn("postrst_load", 0, 32'h10, rd, lat, err, we_rsp, nwe, waddr,
              m_rd, m_lat, m_err, m_wr);

      // Back-to-back loads with req_valid held high
      for (int k = 0; k < 3; k++) begin
         b2b_addr[k] = 32'h40 + 32'(4 * k);
         do_req(1, b2b_addr[k], 2, 0, 32'hC0DE_0000 + 32'(k), rd, lat, err, we_rsp, nwe, waddr);
         model(1, b2b_addr[k], 2, 0, 32'hC0DE_0000 + 32'(k), m_rd, m_lat, m_err, m_wr);
      end
      for (int k = 0; k < 3; k++)
         model(0, b2b_addr[k], 2, 0, 32'h0, b2b_exp[k], m_lat, m_err, m_wr);
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = b2b_addr[0];
      n_acc = 0; n_rsp = 0; guard = 0;
      while (n_rsp < 3 && guard < 100) begin
         guard++;
         if (rsp_valid) begin
            chk($sformatf("b2b_rsp%0d", n_rsp), rsp_rdata, b2b_exp[n_rsp]);
            n_rsp++;
         end
         if (n_acc > n_rsp) chk("b2b_busy_ready", 32'(req_ready), 32'd0);
         if (req_ready && n_acc < 3) begin
            @(posedge clk);
            #1;
            n_acc++;
            if (n_acc < 3) req_addr = b2b_addr[n_acc];
            else req_valid = 1'b0;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("b2b_rsp_count", 32'(n_rsp), 32'd3);

      // Random traffic over a small window of words, random high address bits
      for (int n = 0; n < 150; n++) begin
         we_r    = 1'($urandom_range(0, 1));
         size_r  = 2'($urandom_range(0, 3));
         uns_r   = 1'($urandom_range(0, 1));
         wdata_r = $urandom;
         addr_r  = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
                   | 32'($urandom_range(0, 3));
         model(we_r, addr_r, size_r, uns_r, wdata_r, m_rd, m_lat, m_err, m_wr);
         do_req(we_r, addr_r, size_r, uns_r, wdata_r, rd, lat, err, we_rsp, nwe, waddr);
         chk_txn($sformatf("rnd%0d", n), we_r, addr_r, rd, lat, err, we_rsp, nwe, waddr,
                 m_rd, m_lat, m_err, m_wr);
      end

      // Final memory image
      repeat (2) @(negedge clk);
      nbad = 0;
      for (int i = 0; i < int'(DEPTH); i++) if (mem[i] !== ref_mem[i]) nbad++;
      chk("mem_image_bad_words", 32'(nbad), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/data_mem_lsu.md
DATA_MEM_LSU -- requirements
Module: data_mem_lsu

Interface
REQ-001 Parameter MEM_LAT, default 4: cycles from presentation of mem_addr until the matching mem_dout is valid.
REQ-002 Parameter AW, default 10: memory word-address width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  1  CPU request valid.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_size  input  2  0 = byte, 1 = half, 2 = word; 3 = reserved, handled as word.
REQ-010 req_unsigned  input  1  zero-extend loads when 1, sign-extend when 0.
REQ-011 req_wdata  input  32  store data, right-justified.
REQ-012 rsp_valid  output  1  one-cycle completion pulse.
REQ-013 rsp_rdata  output  32  aligned, extended load data; 0 on stores.
REQ-014 rsp_err  output  1  misaligned access flag, qualified by rsp_valid.
REQ-015 mem_addr  output  AW  word address to the pipelined data memory.
REQ-016 mem_we  output  1  memory write strobe.
REQ-017 mem_din  output  32  memory write word.
REQ-018 mem_dout  input  32  memory read word, valid MEM_LAT cycles after its address.

Function
REQ-019 The block SHALL use FSM states IDLE, LD_WAIT, RMW_RD, RMW_WR, with one request outstanding at a time.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted in the cycle where req_valid && req_ready.
REQ-021 mem_addr SHALL equal req_addr[AW+1:2], registered; higher address bits are ignored.
REQ-022 Word store accepted in cycle A: mem_we=1 and mem_din=req_wdata in cycle A+1 only; rsp_valid=1 in A+1; FSM stays in IDLE.
REQ-023 Load accepted in cycle A: mem_addr is presented in A+1, mem_we=0; the FSM waits in LD_WAIT on a down-counter loaded with MEM_LAT; rsp_valid=1 in A+1+MEM_LAT, with rsp_rdata derived from mem_dout in that same cycle.
REQ-024 Byte/half store, read-modify-write: read in A+1 (RMW_RD); merge the selected lanes of req_wdata into mem_dout in A+1+MEM_LAT; mem_we=1 with the merged word in A+2+MEM_LAT (RMW_WR); rsp_valid in that same cycle.
REQ-025 Lane select: byte lane = addr[1:0]; half lane = addr[1]; load extension per req_size and req_unsigned.
REQ-026 rsp_valid SHALL be a single-cycle pulse with no backpressure; rsp_err=0 unless REQ-033 applies.
REQ-027 While idle, mem_we=0 and mem_addr/mem_din SHALL hold their last values.
REQ-028 Request fields SHALL be captured at acceptance; input changes after acceptance are ignored.

Reset
REQ-029 While rst_n=0, the block SHALL force: FSM=IDLE, counter=0, mem_we=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_addr=0, mem_din=0; req_ready=1 after deassertion.
REQ-030 Reset mid-operation SHALL abort the request: no rsp_valid and no mem_we are produced for it.
REQ-031 Late mem_dout arriving after reset SHALL be ignored.

Configuration
REQ-032 Macro DATA_MEM_LSU_MISALIGN_TRAP_EN SHALL select misalignment handling.
REQ-033 Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=0, SHALL give rsp_valid=1 and rsp_err=1 in A+1, with no memory access.
REQ-034 Undefined: low address bits are forced aligned (half ignores addr[0]; word ignores addr[1:0]), and rsp_err is tied 0.

Structure
REQ-035 Package data_mem_pkg SHALL hold the size encodings, the FSM state enum, and the MEM_LAT default.
REQ-036 The combinational lane extract/extend and merge logic SHALL be sub-module lsu_lane_align.

Verification
REQ-037 Store word 0xDEADBEEF at 0x10, then load word at 0x10 -> mem_we pulse in A+1 with mem_addr=4; load rsp_rdata=0xDEADBEEF exactly MEM_LAT+1 cycles after acceptance.
REQ-038 Load byte at 0x13, signed, from word 0x80FF0102 -> rsp_rdata=0xFFFFFF80; unsigned -> 0x00000080.
REQ-039 Store byte 0xAA to 0x11 over word 0x11223344 -> memory word 0x1122AA44; rsp_valid at A+2+MEM_LAT.
REQ-040 Assert rst_n=0 during LD_WAIT -> no rsp_valid, req_ready=1 after release, next load completes normally.
REQ-041 With DATA_MEM_LSU_MISALIGN_TRAP_EN defined, load word at 0x02 -> rsp_err=1 at A+1, no mem access; without the macro -> reads word address 0.
REQ-042 Hold req_valid=1 with back-to-back loads -> req_ready=0 while in LD_WAIT, one response per request, in order.
